// File: rtl/parity_sched_pkg.sv
// Shared types and default widths for the parity-check scheduler.
package parity_sched_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int CNT_W_DEF       = 16;
    localparam int TIMEOUT_CYC_DEF = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        REPORT
    } state_e;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/parity_rr_arb2.sv
// Two-requester round-robin grant; ready is combinational and only raised while en is high.
// Zero latency: the grant is visible in the same cycle; last_grant moves on the handshake.
module parity_rr_arb2
    import parity_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a_vld,
    input  logic b_vld,
    output logic a_rdy,
    output logic b_rdy,
    output logic grant_src
);

    logic last_grant_q, last_grant_d;
    logic pick_a, pick_b;

    always_comb begin
        // A wins when alone, or when B had the previous grant.
        pick_a       = a_vld && (!b_vld || (last_grant_q == SRC_B));
        pick_b       = b_vld && !pick_a;
        a_rdy        = en && pick_a;
        b_rdy        = en && pick_b;
        grant_src    = pick_b ? SRC_B : SRC_A;
        last_grant_d = last_grant_q;
        if (a_rdy) begin
            last_grant_d = SRC_A;
        end else if (b_rdy) begin
            last_grant_d = SRC_B;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= SRC_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/parity_check_sched.sv
// Shares one parity engine between requesters A and B: accept T, start T+1, result at done+1.
// PARITY_SCHED_TIMEOUT_EN adds a WAIT watchdog and res_timeout_o; otherwise WAIT blocks on done.
module parity_check_sched
    import parity_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
`ifdef PARITY_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              req_a_valid_i,
    input  logic [DATA_W:0]   req_a_word_i,
    output logic              req_a_ready_o,
    input  logic              req_b_valid_i,
    input  logic [DATA_W:0]   req_b_word_i,
    output logic              req_b_ready_o,
    output logic              eng_start_o,
    output logic [DATA_W:0]   eng_word_o,
    input  logic              eng_done_i,
    input  logic              eng_err_i,
    output logic              res_valid_o,
    output logic              res_err_o,
    output logic              res_src_o,
`ifdef PARITY_SCHED_TIMEOUT_EN
    output logic              res_timeout_o,
`endif
    output logic              busy_o,
    input  logic              clr_cnt_i,
    output logic [CNT_W-1:0]  err_cnt_o
);

    state_e            state_q, state_d;
    logic [DATA_W:0]   word_q, word_d;
    logic              src_q, src_d;
    logic              res_err_q, res_err_d;
    logic              res_src_q, res_src_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              arb_en, a_rdy, b_rdy, grant_src;

`ifdef PARITY_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              tmo_flag_q, tmo_flag_d;
`endif

    // Ready is suppressed during reset so every output reads 0 while it is held.
    assign arb_en = (state_q == IDLE) && !wb_rst_i;

    parity_rr_arb2 u_arb (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .en        (arb_en),
        .a_vld     (req_a_valid_i),
        .b_vld     (req_b_valid_i),
        .a_rdy     (a_rdy),
        .b_rdy     (b_rdy),
        .grant_src (grant_src)
    );

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        src_d     = src_q;
        res_err_d = res_err_q;
        res_src_d = res_src_q;
`ifdef PARITY_SCHED_TIMEOUT_EN
        tmo_cnt_d  = '0;
        tmo_flag_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (a_rdy || b_rdy) begin
                    word_d  = (grant_src == SRC_A) ? req_a_word_i : req_b_word_i;
                    src_d   = grant_src;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (eng_done_i) begin
                    res_err_d = eng_err_i;
                    res_src_d = src_q;
                    state_d   = REPORT;
`ifdef PARITY_SCHED_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    res_err_d  = 1'b1;
                    res_src_d  = src_q;
                    tmo_flag_d = 1'b1;
                    state_d    = REPORT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
                end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        err_cnt_d = err_cnt_q;
        if (clr_cnt_i) begin
            err_cnt_d = '0;
        end else if ((state_q == REPORT) && res_err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            word_q    <= '0;
            src_q     <= SRC_A;
            res_err_q <= 1'b0;
            res_src_q <= 1'b0;
            err_cnt_q <= '0;
`ifdef PARITY_SCHED_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            src_q     <= src_d;
            res_err_q <= res_err_d;
            res_src_q <= res_src_d;
            err_cnt_q <= err_cnt_d;
`ifdef PARITY_SCHED_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_flag_q <= tmo_flag_d;
`endif
        end
    end

    assign req_a_ready_o = a_rdy;
    assign req_b_ready_o = b_rdy;
    assign eng_start_o   = (state_q == ISSUE);
    assign eng_word_o    = word_q;
    assign res_valid_o   = (state_q == REPORT);
    assign res_err_o     = res_err_q;
    assign res_src_o     = res_src_q;
    assign busy_o        = (state_q != IDLE);
    assign err_cnt_o     = err_cnt_q;
`ifdef PARITY_SCHED_TIMEOUT_EN
    assign res_timeout_o = tmo_flag_q;
`endif

endmodule

// File: tb/tb_parity_check_sched.sv
// Scoreboard bench for parity_check_sched; a second instance with CNT_W=2 covers saturation.
module tb_parity_check_sched;
    import parity_sched_pkg::*;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i, req_a_valid_i, req_b_valid_i, eng_done_i, eng_err_i, clr_cnt_i;
    logic [8:0]  req_a_word_i, req_b_word_i;
    logic        req_a_ready_o, req_b_ready_o, eng_start_o, res_valid_o, res_err_o, res_src_o, busy_o;
    logic [8:0]  eng_word_o;
    logic [15:0] err_cnt_o;
    logic        s_a_rdy, s_b_rdy, s_start, s_res_valid, s_res_err, s_res_src, s_busy;
    logic [8:0]  s_word;
    logic [1:0]  s_err_cnt;
`ifdef PARITY_SCHED_TIMEOUT_EN
    logic        res_timeout_o, s_res_timeout;
`endif

    parity_check_sched #(
`ifdef PARITY_SCHED_TIMEOUT_EN
        .TIMEOUT_CYC(8),
`endif
        .DATA_W(8), .CNT_W(16)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .req_a_valid_i(req_a_valid_i), .req_a_word_i(req_a_word_i), .req_a_ready_o(req_a_ready_o),
        .req_b_valid_i(req_b_valid_i), .req_b_word_i(req_b_word_i), .req_b_ready_o(req_b_ready_o),
        .eng_start_o(eng_start_o), .eng_word_o(eng_word_o), .eng_done_i(eng_done_i), .eng_err_i(eng_err_i),
        .res_valid_o(res_valid_o), .res_err_o(res_err_o), .res_src_o(res_src_o),
`ifdef PARITY_SCHED_TIMEOUT_EN
        .res_timeout_o(res_timeout_o),
`endif
        .busy_o(busy_o), .clr_cnt_i(clr_cnt_i), .err_cnt_o(err_cnt_o)
    );

    parity_check_sched #(
`ifdef PARITY_SCHED_TIMEOUT_EN
        .TIMEOUT_CYC(8),
`endif
        .DATA_W(8), .CNT_W(2)
    ) dut_sat (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .req_a_valid_i(req_a_valid_i), .req_a_word_i(req_a_word_i), .req_a_ready_o(s_a_rdy),
        .req_b_valid_i(req_b_valid_i), .req_b_word_i(req_b_word_i), .req_b_ready_o(s_b_rdy),
        .eng_start_o(s_start), .eng_word_o(s_word), .eng_done_i(eng_done_i), .eng_err_i(eng_err_i),
        .res_valid_o(s_res_valid), .res_err_o(s_res_err), .res_src_o(s_res_src),
`ifdef PARITY_SCHED_TIMEOUT_EN
        .res_timeout_o(s_res_timeout),
`endif
        .busy_o(s_busy), .clr_cnt_i(clr_cnt_i), .err_cnt_o(s_err_cnt)
    );

    wire [31:0] dut_outs = {req_a_ready_o, req_b_ready_o, eng_start_o, eng_word_o, res_valid_o,
                            res_err_o, res_src_o, busy_o, err_cnt_o};

    always #5 wb_clk_i = ~wb_clk_i;

    int cyc = 0;
    always @(posedge wb_clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];      // {src, err}
    logic [8:0] exp_word_q[$];

    // Engine model: answers each start after eng_delay cycles unless muted.
    int   eng_delay = 1;
    logic eng_err_val = 1'b0;
    bit   eng_mute = 1'b0;
    initial begin
        eng_done_i = 1'b0;
        eng_err_i  = 1'b0;
        forever begin
            @(negedge wb_clk_i);
            if (eng_start_o === 1'b1 && !eng_mute) begin
                repeat (eng_delay) @(posedge wb_clk_i);
                #1 eng_done_i = 1'b1; eng_err_i = eng_err_val;
                @(posedge wb_clk_i);
                #1 eng_done_i = 1'b0; eng_err_i = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b1; req_a_valid_i = 1'b0; req_b_valid_i = 1'b0; clr_cnt_i = 1'b0;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
    endtask

    task automatic test_reset();
        req_a_valid_i = 1'b1; req_b_valid_i = 1'b1;
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        checks++;
        if (dut_outs !== 32'h0) $display("FAIL reset_held: outs=%h required 0", dut_outs);
        @(posedge wb_clk_i); #1;
        req_a_valid_i = 1'b0; req_b_valid_i = 1'b0; wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        checks++;
        if (dut_outs !== 32'h0 || s_err_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_release: outs=%h sat=%0d required 0", dut_outs, s_err_cnt);
        end
    endtask

    task automatic test_single();
        int acc = -1, st = -1;
        bit got = 0;
        logic [1:0] e;
        do_reset();
        eng_delay = 3; eng_err_val = 1'b0;
        @(posedge wb_clk_i); #1;
        req_a_valid_i = 1'b1; req_a_word_i = 9'h0A5;
        @(negedge wb_clk_i);
        checks++;
        if ({req_a_ready_o, req_b_ready_o} !== 2'b10) begin
            errors++; $display("FAIL single_ready: got %b required 10", {req_a_ready_o, req_b_ready_o});
        end
        acc = cyc;
        exp_q.push_back({SRC_A, 1'b0});
        @(posedge wb_clk_i); #1;
        req_a_valid_i = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge wb_clk_i);
            if (eng_start_o) begin
                st = cyc;
                checks++;
                if (st !== acc + 1 || eng_word_o !== 9'h0A5) begin
                    errors++;
                    $display("FAIL single_start: cycle %0d word %h required cycle %0d word 0a5", st, eng_word_o, acc + 1);
                end
            end
            if (res_valid_o) begin
                got = 1;
                e = exp_q.pop_front();
                checks++;
                if (cyc !== st + 4 || res_src_o !== e[1] || res_err_o !== e[0]) begin
                    errors++;
                    $display("FAIL single_result: cycle %0d src %b err %b required cycle %0d src %b err %b",
                             cyc, res_src_o, res_err_o, st + 4, e[1], e[0]);
                end
            end
        end
        checks++;
        if (!got || err_cnt_o !== 16'd0) begin
            errors++; $display("FAIL single_done: got_result %0d err_cnt %0d required 1 and 0", got, err_cnt_o);
        end
    endtask

    task automatic test_contention();
        int grants = 0, results = 0, last_res = -1;
        logic exp_src = SRC_A;
        logic [1:0] e;
        logic [8:0] w;
        do_reset();
        eng_delay = 1; eng_err_val = 1'b0;
        req_a_word_i = 9'h1C3; req_b_word_i = 9'h03C;
        @(posedge wb_clk_i); #1;
        req_a_valid_i = 1'b1; req_b_valid_i = 1'b1;
        for (int k = 0; k < 60 && results < 6; k++) begin
            @(negedge wb_clk_i);
            if (!busy_o && (req_a_valid_i || req_b_valid_i)) begin
                checks++;
                if ((req_a_ready_o ^ req_b_ready_o) !== 1'b1) begin
                    errors++; $display("FAIL one_ready: a %b b %b required exactly one", req_a_ready_o, req_b_ready_o);
                end
            end
            if (req_a_ready_o || req_b_ready_o) begin
                checks++;
                if ({req_a_ready_o, req_b_ready_o} !== ((exp_src == SRC_A) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL grant_order: grant %0d ready %b required src %b", grants,
                                       {req_a_ready_o, req_b_ready_o}, exp_src);
                end
                exp_q.push_back({exp_src, 1'b0});
                exp_word_q.push_back((exp_src == SRC_A) ? 9'h1C3 : 9'h03C);
                exp_src = ~exp_src;
                grants++;
            end
            if (eng_start_o && exp_word_q.size() > 0) begin
                w = exp_word_q.pop_front();
                checks++;
                if (eng_word_o !== w) begin
                    errors++; $display("FAIL eng_word: got %h required %h", eng_word_o, w);
                end
            end
            if (res_valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL unexpected_result: src %b required none", res_src_o);
                end else begin
                    e = exp_q.pop_front();
                    if (res_src_o !== e[1] || res_err_o !== e[0] || (last_res >= 0 && cyc - last_res != 4)) begin
                        errors++;
                        $display("FAIL contention_result: src %b err %b gap %0d required src %b err %b gap 4",
                                 res_src_o, res_err_o, cyc - last_res, e[1], e[0]);
                    end
                end
                last_res = cyc;
                results++;
            end
            @(posedge wb_clk_i); #1;
            if (grants >= 6) begin
                req_a_valid_i = 1'b0; req_b_valid_i = 1'b0;
            end
        end
        checks++;
        if (results != 6 || grants != 6 || exp_q.size() != 0) begin
            errors++; $display("FAIL contention_count: results %0d grants %0d required 6 and 6", results, grants);
        end
    endtask

    task automatic test_errors();
        int exp_cnt = 0, exp_sat = 0;
        bit got;
        logic [1:0] e;
        do_reset();
        eng_delay = 2; eng_err_val = 1'b1;
        for (int n = 0; n < 4; n++) begin
            got = 0;
            @(posedge wb_clk_i); #1;
            req_b_valid_i = 1'b1; req_b_word_i = 9'(9'h040 + n);
            @(negedge wb_clk_i);
            checks++;
            if (req_b_ready_o !== 1'b1) begin
                errors++; $display("FAIL err_ready: word %0d ready %b required 1", n, req_b_ready_o);
            end
            exp_q.push_back({SRC_B, 1'b1});
            @(posedge wb_clk_i); #1;
            req_b_valid_i = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge wb_clk_i);
                if (res_valid_o) begin
                    got = 1;
                    e = exp_q.pop_front();
                    checks++;
                    if (res_src_o !== e[1] || res_err_o !== e[0]) begin
                        errors++; $display("FAIL err_result: src %b err %b required %b %b", res_src_o, res_err_o, e[1], e[0]);
                    end
                    if (n == 3) begin
                        clr_cnt_i = 1'b1; exp_cnt = 0; exp_sat = 0;
                    end else begin
                        exp_cnt++; exp_sat = (exp_sat < 3) ? exp_sat + 1 : 3;
                    end
                end
            end
            @(posedge wb_clk_i); #1;
            clr_cnt_i = 1'b0;
            @(negedge wb_clk_i);
            checks++;
            if (!got || err_cnt_o !== 16'(exp_cnt) || s_err_cnt !== 2'(exp_sat)) begin
                errors++; $display("FAIL err_count: word %0d cnt %0d sat %0d required %0d %0d", n, err_cnt_o, s_err_cnt, exp_cnt, exp_sat);
            end
        end
    endtask

    task automatic test_saturation();
        int exp_cnt = 0, exp_sat = 0;
        bit got;
        eng_delay = 1; eng_err_val = 1'b1;
        for (int n = 0; n < 5; n++) begin
            got = 0;
            @(posedge wb_clk_i); #1;
            req_a_valid_i = 1'b1; req_a_word_i = 9'h1FF;
            @(negedge wb_clk_i);
            if (req_a_ready_o) exp_q.push_back({SRC_A, 1'b1});
            @(posedge wb_clk_i); #1;
            req_a_valid_i = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge wb_clk_i);
                if (res_valid_o && exp_q.size() > 0) begin
                    got = 1;
                    void'(exp_q.pop_front());
                    exp_cnt++; exp_sat = (exp_sat < 3) ? exp_sat + 1 : 3;
                end
            end
            @(negedge wb_clk_i);
            checks++;
            if (!got || err_cnt_o !== 16'(exp_cnt) || s_err_cnt !== 2'(exp_sat)) begin
                errors++; $display("FAIL saturation: word %0d cnt %0d sat %0d required %0d %0d", n, err_cnt_o, s_err_cnt, exp_cnt, exp_sat);
            end
        end
    endtask

    task automatic test_reset_wait();
        bit bad = 0, got = 0;
        eng_mute = 1'b1; eng_err_val = 1'b0; eng_delay = 1;
        @(posedge wb_clk_i); #1;
        req_a_valid_i = 1'b1; req_a_word_i = 9'h155;
        @(negedge wb_clk_i);
        @(posedge wb_clk_i); #1;
        req_a_valid_i = 1'b0;
        @(posedge wb_clk_i); #1;
        @(negedge wb_clk_i);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL rst_wait_busy: got %b required 1", busy_o);
        end
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0; eng_done_i = 1'b1; eng_err_i = 1'b1;
        @(negedge wb_clk_i);
        checks++;
        if (dut_outs !== 32'h0 || s_err_cnt !== 2'd0) begin
            errors++; $display("FAIL rst_wait_outs: outs %h sat %0d required 0", dut_outs, s_err_cnt);
        end
        @(posedge wb_clk_i); #1;
        eng_done_i = 1'b0; eng_err_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge wb_clk_i);
            if (res_valid_o !== 1'b0 || busy_o !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL late_done: res_valid/busy seen high, required 0");
        end
        @(posedge wb_clk_i); #1;
        req_a_valid_i = 1'b1; req_b_valid_i = 1'b1;
        @(negedge wb_clk_i);
        checks++;
        if ({req_a_ready_o, req_b_ready_o} !== 2'b10) begin
            errors++; $display("FAIL rst_first_grant: got %b required 10", {req_a_ready_o, req_b_ready_o});
        end
        exp_q.push_back({SRC_A, 1'b0});
        @(posedge wb_clk_i); #1;
        req_a_valid_i = 1'b0; req_b_valid_i = 1'b0; eng_mute = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge wb_clk_i);
            if (res_valid_o) got = 1;
        end
        checks++;
        if (!got || res_src_o !== exp_q[0][1] || res_err_o !== exp_q[0][0]) begin
            errors++; $display("FAIL rst_after_result: got %0d src %b err %b required 1 %b %b", got, res_src_o, res_err_o, exp_q[0][1], exp_q[0][0]);
        end
        exp_q.delete();
    endtask

`ifdef PARITY_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int st = -1;
        bit got = 0;
        do_reset();
        eng_mute = 1'b1;
        @(posedge wb_clk_i); #1;
        req_a_valid_i = 1'b1; req_a_word_i = 9'h0A5;
        @(negedge wb_clk_i);
        @(posedge wb_clk_i); #1;
        req_a_valid_i = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge wb_clk_i);
            if (eng_start_o) st = cyc;
            if (res_valid_o) begin
                got = 1;
                checks++;
                if (cyc !== st + 9 || res_err_o !== 1'b1 || res_timeout_o !== 1'b1) begin
                    errors++; $display("FAIL timeout_result: cycle %0d err %b tmo %b required %0d 1 1", cyc, res_err_o, res_timeout_o, st + 9);
                end
            end
        end
        @(negedge wb_clk_i);
        checks++;
        if (!got || err_cnt_o !== 16'd1 || res_timeout_o !== 1'b0) begin
            errors++; $display("FAIL timeout_after: got %0d cnt %0d tmo %b required 1 1 0", got, err_cnt_o, res_timeout_o);
        end
        eng_mute = 1'b0;
    endtask
`endif

    initial begin
        wb_rst_i = 1'b1; clr_cnt_i = 1'b0;
        req_a_valid_i = 1'b0; req_b_valid_i = 1'b0;
        req_a_word_i = 9'h0; req_b_word_i = 9'h0;
        test_reset();
        test_single();
        test_contention();
        test_errors();
        test_saturation();
        test_reset_wait();
`ifdef PARITY_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
